// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: hunts for a sync pattern, shifts in a
// WIDTH-bit word MSB first, optionally checks even parity, strobes the word out.
module sipo_frame_rx #(
    parameter int                  WIDTH     = 8,
    parameter int                  SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC      = 8'hB1,
    parameter bit                  PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             parity_err,
    output logic             sync_lock,
    output logic [7:0]       frame_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_r;
    logic [SYNC_LEN-1:0] sreg_r;
    logic [WIDTH-1:0]    data_r;
    logic [CNT_W-1:0]    bit_cnt_r;

    logic [SYNC_LEN-1:0] sync_next_s;
    logic [WIDTH-1:0]    data_next_s;
    logic                perr_s;
    logic                last_bit_s;

    // Even parity over data plus parity bit: a nonzero result is an error.
    function automatic logic even_parity_fail(input logic [WIDTH-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    // Next-value helpers for the shift registers and parity check.
    always_comb begin
        sync_next_s = {sreg_r[SYNC_LEN-2:0], din};
        data_next_s = {data_r[WIDTH-2:0], din};
        perr_s      = even_parity_fail(data_r, din);
        if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Receiver FSM with registered outputs; strobes clear on every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= HUNT;
            sreg_r     <= '0;
            data_r     <= '0;
            bit_cnt_r  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            sync_lock  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            if (din_en) begin
                case (state_r)
                    HUNT: begin
                        // Sync register is cleared on lock so data bits never feed a later match.
                        if (sync_next_s == SYNC) begin
                            state_r   <= DATA;
                            sreg_r    <= '0;
                            bit_cnt_r <= '0;
                            sync_lock <= 1'b1;
                        end else begin
                            sreg_r <= sync_next_s;
                        end
                    end
                    DATA: begin
                        data_r <= data_next_s;
                        if (!last_bit_s) begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end else if (PARITY_EN) begin
                            state_r <= PARITY;
                        end else begin
                            state_r    <= HUNT;
                            dout       <= data_next_s;
                            dout_valid <= 1'b1;
                            sync_lock  <= 1'b0;
                            frame_cnt  <= frame_cnt + 8'd1;
                        end
                    end
                    PARITY: begin
                        state_r    <= HUNT;
                        dout       <= data_r;
                        dout_valid <= 1'b1;
                        parity_err <= perr_s;
                        sync_lock  <= 1'b0;
                        if (!perr_s) begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state_r   <= HUNT;
                        sreg_r    <= '0;
                        sync_lock <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: table-driven frames plus corner-case
// sequences, with a queue scoreboard checking every dout_valid strobe.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din0, din_en0, din1, din_en1;
    logic [7:0] dout0, dout1, cnt0, cnt1;
    logic       dv0, dv1, perr0, perr1, lock0, lock1;

    always #5 clk = ~clk;

    sipo_frame_rx u_dut0 (
        .clk(clk), .rst_n(rst_n), .din(din0), .din_en(din_en0),
        .dout(dout0), .dout_valid(dv0), .parity_err(perr0),
        .sync_lock(lock0), .frame_cnt(cnt0)
    );

    sipo_frame_rx #(.PARITY_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_en(din_en1),
        .dout(dout1), .dout_valid(dv1), .parity_err(perr1),
        .sync_lock(lock1), .frame_cnt(cnt1)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        int         gap;
        logic       exp_perr;
    } vec_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] exp_cnt0, exp_cnt1;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: compare any strobe against the oldest pending expectation.
    task automatic monitor();
        exp_t e;
        chk("perr0_without_valid", (perr0 && !dv0) ? 1 : 0, 0);
        if (dv0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_strobe", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("dut0_dout", dout0, e.d);
                chk("dut0_parity_err", perr0, e.pe);
                chk("dut0_frame_cnt", cnt0, e.cnt);
                chk("dut0_lock_drop", lock0, 0);
            end
        end
        if (dv1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_strobe", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_dout", dout1, e.d);
                chk("dut1_parity_err", perr1, 0);
                chk("dut1_frame_cnt", cnt1, e.cnt);
                chk("dut1_lock_drop", lock1, 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic put_bit(input int sel, input logic b, input int gap);
        if (sel == 0) begin din0 = b; din_en0 = 1'b1; end
        else          begin din1 = b; din_en1 = 1'b1; end
        tick();
        din_en0 = 1'b0;
        din_en1 = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push(input int sel, input logic [7:0] d, input logic pe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        if (sel == 0) begin
            if (!pe) exp_cnt0 = exp_cnt0 + 8'd1;
            e.cnt = exp_cnt0;
            q0.push_back(e);
        end else begin
            exp_cnt1 = exp_cnt1 + 8'd1;
            e.cnt = exp_cnt1;
            q1.push_back(e);
        end
    endtask

    task automatic send_sync(input int sel, input int gap);
        logic [7:0] sp;
        sp = 8'hB1;
        for (int i = 7; i >= 0; i--) put_bit(sel, sp[i], gap);
        chk("sync_lock_after_sync", (sel == 0) ? lock0 : lock1, 1);
    endtask

    task automatic send_payload(input int sel, input logic [7:0] data, input logic pbit,
                                input int gap, input logic exp_perr);
        logic last;
        for (int i = 7; i >= 0; i--) begin
            last = (sel == 1) && (i == 0);
            if (last) push(1, data, 1'b0);
            put_bit(sel, data[i], last ? 0 : gap);
        end
        if (sel == 0) begin
            push(0, data, exp_perr);
            put_bit(0, pbit, 0);
        end
        chk("strobe_at_last_bit_edge", (sel == 0) ? q0.size() : q1.size(), 0);
        chk("sync_lock_after_emit", (sel == 0) ? lock0 : lock1, 0);
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        din_en0 = 1'b0;
        din_en1 = 1'b0;
        tick();
        rst_n    = 1'b1;
        exp_cnt0 = 8'd0;
        exp_cnt1 = 8'd0;
    endtask

    vec_t        tbl[8];
    logic [19:0] nm;
    logic [7:0]  rnd;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 0, 1'b1};
        tbl[2] = '{8'h3C, 1'b0, 0, 1'b0};
        tbl[3] = '{8'hA5, 1'b0, 3, 1'b0};
        tbl[4] = '{8'h00, 1'b0, 0, 1'b0};
        tbl[5] = '{8'h01, 1'b1, 1, 1'b0};
        tbl[6] = '{8'h80, 1'b0, 0, 1'b1};
        tbl[7] = '{8'hFF, 1'b1, 2, 1'b1};

        din0 = 1'b0; din1 = 1'b0;
        do_reset();
        do_reset();
        chk("reset_dout", dout0, 0);
        chk("reset_valid", dv0, 0);
        chk("reset_perr", perr0, 0);
        chk("reset_lock", lock0, 0);
        chk("reset_cnt", cnt0, 0);

        // Table-driven frames: good/bad parity, gapped din_en, edge data values.
        for (int v = 0; v < 8; v++) begin
            send_sync(0, tbl[v].gap);
            send_payload(0, tbl[v].data, tbl[v].pbit, tbl[v].gap, tbl[v].exp_perr);
        end
        chk("cnt_after_table", cnt0, 8'd5);

        // Near-miss followed by an overlapping sync prefix.
        nm = 20'b1011_0000_1011_1011_0001;
        for (int i = 19; i >= 0; i--) begin
            put_bit(0, nm[i], 0);
            if (i == 12) chk("no_lock_near_miss", lock0, 0);
            if (i == 1)  chk("no_lock_before_last", lock0, 0);
        end
        chk("lock_on_overlap", lock0, 1);
        send_payload(0, 8'hFF, 1'b0, 0, 1'b0);

        // Reset after the 4th data bit abandons the frame.
        send_sync(0, 0);
        for (int i = 7; i >= 4; i--) put_bit(0, tbl[0].data[i], 0);
        do_reset();
        chk("midreset_dout", dout0, 0);
        chk("midreset_valid", dv0, 0);
        chk("midreset_lock", lock0, 0);
        chk("midreset_cnt", cnt0, 0);
        repeat (2) tick();
        send_sync(0, 0);
        send_payload(0, 8'h5A, 1'b0, 0, 1'b0);
        chk("cnt_after_5a", cnt0, 8'd1);

        // No-parity variant: 256 back-to-back frames wrap the counter.
        for (int f = 1; f <= 256; f++) begin
            rnd = 8'($urandom_range(0, 255));
            send_sync(1, 0);
            send_payload(1, rnd, 1'b0, 0, 1'b0);
            if (f == 255) chk("cnt_255", cnt1, 8'd255);
            if (f == 256) chk("cnt_wrap", cnt1, 8'd0);
        end
        chk("dut0_idle_cnt", cnt0, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
